// File: rtl/mmix_defs.sv
// Shared MMIX memory-interface definitions: access-size codes and the
// bridge state encoding.
package mmix_defs;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WYDE  = 2'd1;
    localparam logic [1:0] SZ_TETRA = 2'd2;
    localparam logic [1:0] SZ_OCTA  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/mmix_lane_steer.sv
// Big-endian byte-lane steering between a right-aligned MMIX value and a
// 32-bit Avalon word. Byte offset j within a word lives on lane 3-j.
module mmix_lane_steer
    import mmix_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        beat,
    input  logic [63:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] rword
);

    // Lane enables, write-word placement and right-aligned read extraction.
    always_comb begin
        byteenable = 4'b0000;
        writedata  = 32'h0;
        rword      = 32'h0;
        case (size)
            SZ_BYTE: begin
                byteenable = 4'b1000 >> addr_lo;
                writedata  = {4{wdata[7:0]}};
                case (addr_lo)
                    2'd0:    rword = {24'h0, rdata[31:24]};
                    2'd1:    rword = {24'h0, rdata[23:16]};
                    2'd2:    rword = {24'h0, rdata[15:8]};
                    default: rword = {24'h0, rdata[7:0]};
                endcase
            end
            SZ_WYDE: begin
                if (addr_lo[1] == 1'b0) begin
                    byteenable = 4'b1100;
                    writedata  = {wdata[15:0], 16'h0};
                    rword      = {16'h0, rdata[31:16]};
                end else begin
                    byteenable = 4'b0011;
                    writedata  = {16'h0, wdata[15:0]};
                    rword      = {16'h0, rdata[15:0]};
                end
            end
            SZ_TETRA: begin
                byteenable = 4'b1111;
                writedata  = wdata[31:0];
                rword      = rdata;
            end
            default: begin
                // Octa: the high word goes out first (lower address).
                byteenable = 4'b1111;
                writedata  = beat ? wdata[31:0] : wdata[63:32];
                rword      = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mmix_mem_bridge.sv
// Bridges the exec stage's level-held 64-bit memory request onto a 32-bit
// big-endian Avalon-MM master, one transaction outstanding at a time.
//
// state  | meaning
// IDLE   | waiting for mem_read / mem_write (read wins if both)
// RD     | avm_read asserted until accepted
// RWAIT  | waiting for avm_readdatavalid of the current beat
// WR     | avm_write asserted until accepted (octa does two beats here)
// DONE   | mem_done pulse, back to IDLE
module mmix_mem_bridge
    import mmix_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       mem_address,
    input  logic [1:0]        mem_datasize,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       mem_writedata,
    output logic [63:0]       mem_readdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    bridge_state_t     state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [63:0]       wdata_q;
    logic              beat_q;
    logic [31:0]       hi_word_q;

    logic              is_octa;
    logic              last_beat;
    logic              take_req;
    logic              strobe;
    logic [ADDR_W-1:0] beat_addr;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rword;

    // MMIX address bits above the Avalon address width are dropped.
    if (ADDR_W < 64) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_address[63:ADDR_W];
    end

    assign is_octa   = (size_q == SZ_OCTA);
    assign last_beat = !is_octa || beat_q;
    assign take_req  = (state == ST_IDLE) && (mem_read || mem_write);
    assign beat_addr = is_octa ? {addr_q[ADDR_W-1:3], beat_q, 2'b00}
                               : {addr_q[ADDR_W-1:2], 2'b00};

    mmix_lane_steer u_steer (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .beat       (beat_q),
        .wdata      (wdata_q),
        .rdata      (avm_readdata),
        .byteenable (lane_be),
        .writedata  (lane_wdata),
        .rword      (lane_rword)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (mem_read)       state_next = ST_RD;
                else if (mem_write) state_next = ST_WR;
            end
            ST_RD: begin
                if (!avm_waitrequest) state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (avm_readdatavalid) state_next = last_beat ? ST_DONE : ST_RD;
            end
            ST_WR: begin
                if (!avm_waitrequest && last_beat) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, beat counter and read-data capture. mem_readdata only
    // changes when a read completes so a half-finished octa is never seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            wdata_q      <= 64'h0;
            beat_q       <= 1'b0;
            hi_word_q    <= 32'h0;
            mem_readdata <= 64'h0;
        end else begin
            if (take_req) begin
                addr_q  <= mem_address[ADDR_W-1:0];
                size_q  <= mem_datasize;
                wdata_q <= mem_writedata;
                beat_q  <= 1'b0;
            end
            if (state == ST_RWAIT && avm_readdatavalid) begin
                if (!last_beat) begin
                    hi_word_q <= avm_readdata;
                    beat_q    <= 1'b1;
                end else if (is_octa) begin
                    mem_readdata <= {hi_word_q, avm_readdata};
                end else begin
                    mem_readdata <= {32'h0, lane_rword};
                end
            end
            if (state == ST_WR && !avm_waitrequest && !last_beat) begin
                beat_q <= 1'b1;
            end
        end
    end

    // Outputs decode purely from registered state, so they are glitch-free
    // and frozen while waitrequest stalls a strobe.
    always_comb begin
        avm_read       = (state == ST_RD);
        avm_write      = (state == ST_WR);
        mem_done       = (state == ST_DONE);
        strobe         = avm_read || avm_write;
        avm_address    = strobe ? beat_addr : '0;
        avm_byteenable = strobe ? lane_be : 4'b0000;
        avm_writedata  = avm_write ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Directed bench for mmix_mem_bridge with a small zero/fixed-latency
// Avalon slave and hand-computed expectations.
module tb_mmix_mem_bridge;

    logic        clk;
    logic        reset_n;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         wlog[$];
    wr_t         w;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic        stray_valid = 1'b0;
    logic        rd_accept = 1'b0;
    logic [31:0] rd_addr = 32'h0;
    int          n;
    int          d0;

    mmix_mem_bridge #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mem_address       (mem_address),
        .mem_datasize      (mem_datasize),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_done          (mem_done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slave_mem(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hAABB_CCDD;
            32'h0000_2000: return 32'h0123_4567;
            32'h0000_2004: return 32'h89AB_CDEF;
            32'h0000_0010: return 32'hCAFE_F00D;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        avm_readdatavalid = rd_accept || stray_valid;
        if (rd_accept) avm_readdata = slave_mem(rd_addr);
        if ((avm_read || avm_write) && stall_cnt > 0 && avm_address == stall_addr) begin
            avm_waitrequest = 1'b1;
            stall_cnt--;
        end else begin
            avm_waitrequest = 1'b0;
        end
        rd_accept = avm_read && !avm_waitrequest;
        rd_addr   = avm_address;
        if (avm_write && !avm_waitrequest)
            wlog.push_back('{a: avm_address, d: avm_writedata, be: avm_byteenable});
        if (mem_done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (mem_done) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        mem_address       = 64'h0;
        mem_datasize      = 2'd0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_writedata     = 64'h0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'h0;
        avm_readdatavalid = 1'b0;
        tick();
        checks++; if (mem_readdata !== 64'h0) begin errors++; $error("FAIL rst_readdata: %0h", mem_readdata); end
        checks++; if (mem_done !== 1'b0) begin errors++; $error("FAIL rst_done"); end
        checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $error("FAIL rst_strobes"); end
        checks++; if (avm_address !== 32'h0) begin errors++; $error("FAIL rst_address: %0h", avm_address); end
        checks++; if (avm_byteenable !== 4'h0) begin errors++; $error("FAIL rst_be: %0h", avm_byteenable); end
        reset_n = 1'b1;
        tick();

        mem_address = 64'h1003; mem_datasize = 2'd0; mem_read = 1'b1;
        tick();
        checks++; if (avm_read !== 1'b1) begin errors++; $error("FAIL ldb_read"); end
        checks++; if (avm_address !== 32'h1000) begin errors++; $error("FAIL ldb_addr: %0h", avm_address); end
        checks++; if (avm_byteenable !== 4'b0001) begin errors++; $error("FAIL ldb_be: %0h", avm_byteenable); end
        tick();
        checks++; if (avm_read !== 1'b0) begin errors++; $error("FAIL ldb_read_one_cycle"); end
        checks++; if (mem_done !== 1'b0) begin errors++; $error("FAIL ldb_no_early_done"); end
        tick();
        checks++; if (mem_done !== 1'b1) begin errors++; $error("FAIL ldb_done_lat3"); end
        checks++; if (mem_readdata !== 64'h0000_0000_0000_00DD) begin errors++; $error("FAIL ldb_data: %0h", mem_readdata); end
        mem_read = 1'b0;
        tick();
        checks++; if (mem_done !== 1'b0) begin errors++; $error("FAIL ldb_done_pulse"); end

        mem_address = 64'h1002; mem_datasize = 2'd1; mem_writedata = 64'h1234; mem_write = 1'b1;
        tick();
        checks++; if (avm_write !== 1'b1) begin errors++; $error("FAIL stw_write"); end
        checks++; if (avm_byteenable !== 4'b0011) begin errors++; $error("FAIL stw_be: %0h", avm_byteenable); end
        checks++; if (avm_writedata[15:0] !== 16'h1234) begin errors++; $error("FAIL stw_data: %0h", avm_writedata); end
        checks++; if (avm_address !== 32'h1000) begin errors++; $error("FAIL stw_addr: %0h", avm_address); end
        tick();
        checks++; if (mem_done !== 1'b1) begin errors++; $error("FAIL stw_done"); end
        checks++; if (mem_readdata !== 64'h0000_0000_0000_00DD) begin errors++; $error("FAIL stw_rdata_held: %0h", mem_readdata); end
        checks++; if (wlog.size() !== 1) begin errors++; $error("FAIL stw_log_n: %0d", wlog.size()); end
        w = wlog.pop_front();
        checks++; if (w !== {32'h1000, 32'h0000_1234, 4'b0011}) begin errors++; $error("FAIL stw_log: %0h", w); end
        mem_write = 1'b0;
        tick();
        mem_address = 64'h10; mem_datasize = 2'd2; mem_read = 1'b1;
        tick();
        checks++; if (avm_read !== 1'b1) begin errors++; $error("FAIL b2b_read"); end
        checks++; if (avm_address !== 32'h10) begin errors++; $error("FAIL b2b_addr: %0h", avm_address); end
        wait_done(10, n);
        checks++; if (n !== 2) begin errors++; $error("FAIL b2b_lat: %0d", n); end
        checks++; if (mem_readdata !== 64'h0000_0000_CAFE_F00D) begin errors++; $error("FAIL b2b_data: %0h", mem_readdata); end
        mem_read = 1'b0;
        tick();

        d0 = done_cnt;
        mem_address = 64'h2005; mem_datasize = 2'd3; mem_read = 1'b1;
        tick();
        checks++; if (avm_address !== 32'h2000) begin errors++; $error("FAIL ldo_addr0: %0h", avm_address); end
        checks++; if (avm_read !== 1'b1) begin errors++; $error("FAIL ldo_read0"); end
        tick();
        checks++; if (mem_readdata !== 64'h0000_0000_CAFE_F00D) begin errors++; $error("FAIL ldo_no_done_mid: %0h", mem_readdata); end
        tick();
        checks++; if (avm_address !== 32'h2004) begin errors++; $error("FAIL ldo_addr1: %0h", avm_address); end
        checks++; if (avm_read !== 1'b1) begin errors++; $error("FAIL ldo_read1"); end
        tick();
        tick();
        checks++; if (mem_done !== 1'b1) begin errors++; $error("FAIL ldo_done_lat5"); end
        checks++; if (mem_readdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $error("FAIL ldo_data: %0h", mem_readdata); end
        mem_read = 1'b0;
        tick();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $error("FAIL ldo_one_done: %0d", done_cnt - d0); end

        stall_addr = 32'h3004; stall_cnt = 3;
        mem_address = 64'h3000; mem_datasize = 2'd3;
        mem_writedata = 64'h1122_3344_5566_7788; mem_write = 1'b1;
        tick();
        checks++;
        if ({avm_write, avm_address, avm_writedata, avm_byteenable} !==
            {1'b1, 32'h3000, 32'h1122_3344, 4'hF}) begin
            errors++; $error("FAIL sto_beat0");
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({avm_write, avm_address, avm_writedata, avm_byteenable} !==
                {1'b1, 32'h3004, 32'h5566_7788, 4'hF}) begin
                errors++; $error("FAIL sto_beat1_stable cycle %0d", i);
            end
            checks++;
            if (mem_done !== 1'b0) begin
                errors++; $error("FAIL sto_no_early_done cycle %0d", i);
            end
        end
        tick();
        checks++; if (mem_done !== 1'b1) begin errors++; $error("FAIL sto_done"); end
        mem_write = 1'b0;
        checks++; if (wlog.size() !== 2) begin errors++; $error("FAIL sto_log_n: %0d", wlog.size()); end
        w = wlog.pop_front();
        checks++; if (w !== {32'h3000, 32'h1122_3344, 4'hF}) begin errors++; $error("FAIL sto_log0: %0h", w); end
        w = wlog.pop_front();
        checks++; if (w !== {32'h3004, 32'h5566_7788, 4'hF}) begin errors++; $error("FAIL sto_log1: %0h", w); end
        tick();

        mem_address = 64'h2000; mem_datasize = 2'd2; mem_read = 1'b1; mem_write = 1'b1;
        tick();
        checks++; if ({avm_read, avm_write} !== 2'b10) begin errors++; $error("FAIL both_strobes"); end
        wait_done(10, n);
        checks++; if (n !== 2) begin errors++; $error("FAIL both_lat: %0d", n); end
        checks++; if (mem_readdata !== 64'h0000_0000_0123_4567) begin errors++; $error("FAIL both_data: %0h", mem_readdata); end
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
        checks++; if (wlog.size() !== 0) begin errors++; $error("FAIL both_no_write: %0d", wlog.size()); end

        d0 = done_cnt;
        mem_address = 64'h1000; mem_datasize = 2'd2; mem_read = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        mem_read = 1'b0;
        #1;
        checks++; if (avm_read !== 1'b0) begin errors++; $error("FAIL rst_mid_strobe"); end
        checks++; if (mem_done !== 1'b0) begin errors++; $error("FAIL rst_mid_done"); end
        checks++; if (mem_readdata !== 64'h0) begin errors++; $error("FAIL rst_mid_rdata: %0h", mem_readdata); end
        tick();
        reset_n = 1'b1;
        stray_valid = 1'b1;
        tick();
        tick();
        stray_valid = 1'b0;
        tick();
        tick();
        checks++; if (done_cnt - d0 !== 0) begin errors++; $error("FAIL rst_stray_no_done: %0d", done_cnt - d0); end
        checks++; if (mem_readdata !== 64'h0) begin errors++; $error("FAIL rst_stray_rdata: %0h", mem_readdata); end
        checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $error("FAIL rst_stray_idle"); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
